// File: rtl/spi_master_4mb_if.sv
// SPI master bundle: host request/response signals plus the four SPI pins.
// The master modport is the SPI master's own view of the bundle.
// The slave modport is the view of whatever drives requests and models the SPI slave.
interface spi_master_4mb_if;
  logic        start;
  logic [1:0]  cs_sel;
  logic [15:0] tx_addr;
  logic [31:0] tx_data;
  logic        busy;
  logic        done;
  logic [31:0] rx_data;
  logic        mclk;
  logic        mosi;
  logic        miso;
  logic [3:0]  cs_n;

  modport master (
    input  start, cs_sel, tx_addr, tx_data, miso,
    output busy, done, rx_data, mclk, mosi, cs_n
  );

  modport slave (
    output start, cs_sel, tx_addr, tx_data, miso,
    input  busy, done, rx_data, mclk, mosi, cs_n
  );
endinterface

// File: rtl/spi_master_4mb.sv
// SPI mode-3 master: one 48-bit full-duplex frame (16b addr + 32b data) to one of 4 slaves.
// Latency: cs_n low for CS_SETUP + 96*CLK_DIV + CS_HOLD cycles, done then IDLE_GAP cycles of idle.
// No queuing: start is only looked at in IDLE; requests while busy are dropped.
module spi_master_4mb #(
  parameter int unsigned CLK_DIV  = 5,
  parameter int unsigned CS_SETUP = 4,
  parameter int unsigned CS_HOLD  = 4,
  parameter int unsigned IDLE_GAP = 10
) (
  input  logic             clk_100m,
  input  logic             rst_n,
  spi_master_4mb_if.master bus
);

  // Terminal counts for the shared cycle counter, one per timed state.
  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_LAST   = 8'(IDLE_GAP - 1);
  localparam logic [5:0] FRAME_BITS = 6'd48;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;       // cycles spent in the current state / half-period
  logic [5:0]  bit_cnt_q;   // mclk rising edges seen this frame, saturates at 48
  logic [47:0] tx_sh_q;     // frame being shifted out, bit 47 is on the wire
  logic [31:0] rx_sh_q;     // last 32 MISO samples; older address-phase bits fall off the top
  logic        mclk_q;
  logic        mosi_q;
  logic [3:0]  cs_n_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] rx_data_q;

  logic        cnt_end;
  logic [3:0]  cs_n_sel;

  // Active-low one-hot decode of the requested slave, captured only on accept.
  assign cs_n_sel = ~(4'b0001 << bus.cs_sel);

  // Terminal-count detect for whichever interval the FSM is currently timing.
  always_comb begin
    cnt_end = 1'b0;
    case (state_q)
      SETUP:   cnt_end = (cnt_q == SETUP_LAST);
      SHIFT:   cnt_end = (cnt_q == DIV_LAST);
      HOLD:    cnt_end = (cnt_q == HOLD_LAST);
      GAP:     cnt_end = (cnt_q == GAP_LAST);
      default: cnt_end = 1'b0;
    endcase
  end

  // Frame sequencer; every pin and status output is a register updated here.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      mclk_q    <= 1'b1;
      mosi_q    <= 1'b1;
      cs_n_q    <= 4'hF;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rx_data_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            // Everything the frame needs is captured here, so later input
            // changes cannot disturb it.
            state_q   <= SETUP;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            tx_sh_q   <= {bus.tx_addr, bus.tx_data};
            mosi_q    <= bus.tx_addr[15];
            mclk_q    <= 1'b1;
            cs_n_q    <= cs_n_sel;
            busy_q    <= 1'b1;
          end
        end

        SETUP: begin
          if (cnt_end) begin
            // First falling edge; mosi already holds bit 47 from accept.
            state_q <= SHIFT;
            cnt_q   <= '0;
            mclk_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        SHIFT: begin
          if (!cnt_end) begin
            cnt_q <= cnt_q + 8'd1;
          end else begin
            cnt_q <= '0;
            if (!mclk_q) begin
              // End of low half: rising edge, sample MISO on this same edge.
              mclk_q  <= 1'b1;
              rx_sh_q <= {rx_sh_q[30:0], bus.miso};
              if (bit_cnt_q != FRAME_BITS) begin
                bit_cnt_q <= bit_cnt_q + 6'd1;
              end
            end else if (bit_cnt_q == FRAME_BITS) begin
              // High half of the last bit is over; mclk stays high through HOLD.
              state_q <= HOLD;
            end else begin
              // Falling edge of the next bit: present the next MOSI bit.
              mclk_q  <= 1'b0;
              mosi_q  <= tx_sh_q[46];
              tx_sh_q <= {tx_sh_q[46:0], 1'b1};
            end
          end
        end

        HOLD: begin
          if (cnt_end) begin
            state_q   <= GAP;
            cnt_q     <= '0;
            cs_n_q    <= 4'hF;
            mosi_q    <= 1'b1;
            done_q    <= 1'b1;
            rx_data_q <= rx_sh_q;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        GAP: begin
          if (cnt_end) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          mclk_q  <= 1'b1;
          mosi_q  <= 1'b1;
          cs_n_q  <= 4'hF;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mclk    = mclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.cs_n    = cs_n_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master_4mb.sv
// Bench for spi_master_4mb: default-parameter instance with a mode-3 slave model,
// plus a CLK_DIV=2 instance with MISO tied high. Stimulus pushes expected frames
// into queues; monitors pop and compare on every done pulse.
module tb_spi_master_4mb;

  localparam int CS_LOW_LEN   = 4 + 96 * 5 + 4;   // 488
  localparam int HOLD_LEN     = 5 + 4;            // last rise -> cs_n rise
  localparam int SCLK_PERIOD  = 10;
  localparam int SETUP_LEN    = 4;
  localparam int IDLE_GAP     = 10;
  localparam int FAST_LOW_LEN = 4 + 96 * 2 + 4;   // 200
  localparam int FAST_PERIOD  = 4;

  logic clk_100m = 1'b0;
  logic rst_n;
  always #5 clk_100m = ~clk_100m;

  spi_master_4mb_if ifa ();
  spi_master_4mb_if ifb ();

  spi_master_4mb dut (
    .clk_100m (clk_100m),
    .rst_n    (rst_n),
    .bus      (ifa.master)
  );

  spi_master_4mb #(.CLK_DIV(2)) dut_fast (
    .clk_100m (clk_100m),
    .rst_n    (rst_n),
    .bus      (ifb.master)
  );

  assign ifb.miso = 1'b1;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;
  always @(posedge clk_100m) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [47:0] frame;
    logic [31:0] rx;
    logic [3:0]  cs;
    int          gap;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] fast_q[$];
  exp_t        cur;
  logic [31:0] fast_cur;
  logic [31:0] slave_word;

  task automatic expect_frame(input logic [15:0] a, input logic [31:0] d,
                              input logic [31:0] rx, input logic [3:0] cs, input int gap);
    exp_t e;
    e.frame = {a, d};
    e.rx    = rx;
    e.cs    = cs;
    e.gap   = gap;
    exp_q.push_back(e);
  endtask

  // ---------------- monitor + slave model for the default instance ----------------
  logic [3:0]  prev_cs = 4'hF;
  logic        prev_mclk = 1'b1;
  logic        prev_busy = 1'b0;
  bit          in_frame = 0, have_rise = 0, multi_low = 0, chk_done_low = 0;
  logic [3:0]  cs_val;
  int          t_fall, t_rise, t_first_sclk, t_last_rise;
  int          pulses, sclk_falls, cs_len, hold_len, period, gap;
  logic [47:0] mosi_cap, miso_sh;

  always @(negedge clk_100m) begin
    if (!rst_n) begin
      in_frame     = 0;
      have_rise    = 0;
      chk_done_low = 0;
      prev_cs      = 4'hF;
      prev_mclk    = 1'b1;
      prev_busy    = 1'b0;
      ifa.miso     = 1'b1;
    end else begin
      if (chk_done_low) begin
        chk("done_width", ifa.done, 1'b0);
        chk_done_low = 0;
      end
      if (prev_cs == 4'hF && ifa.cs_n != 4'hF) begin
        in_frame   = 1;
        cs_val     = ifa.cs_n;
        t_fall     = cyc;
        pulses     = 0;
        sclk_falls = 0;
        period     = 0;
        multi_low  = 0;
        mosi_cap   = '0;
        gap        = have_rise ? (cyc - t_rise) : -1;
        miso_sh    = {16'h3C3C, slave_word};
        ifa.miso   = miso_sh[47];
      end
      if (in_frame && ifa.cs_n != 4'hF && ifa.cs_n != cs_val) multi_low = 1;
      if (in_frame && prev_mclk && !ifa.mclk) begin
        if (sclk_falls == 0) t_first_sclk = cyc;
        else begin
          miso_sh  = {miso_sh[46:0], 1'b1};
          ifa.miso = miso_sh[47];
        end
        sclk_falls++;
      end
      if (in_frame && !prev_mclk && ifa.mclk) begin
        pulses++;
        mosi_cap = {mosi_cap[46:0], ifa.mosi};
        if (pulses == 2) period = cyc - t_last_rise;
        t_last_rise = cyc;
      end
      if (in_frame && ifa.cs_n == 4'hF) begin
        in_frame  = 0;
        have_rise = 1;
        t_rise    = cyc;
        cs_len    = cyc - t_fall;
        hold_len  = cyc - t_last_rise;
      end
      if (ifa.done) begin
        chk_done_low = 1;
        if (exp_q.size() == 0) chk("unexpected_done", 1'b1, 1'b0);
        else begin
          cur = exp_q.pop_front();
          chk("cs_sel", cs_val, cur.cs);
          chk("mosi_frame", mosi_cap, cur.frame);
          chk("rx_data", ifa.rx_data, cur.rx);
          chk("sclk_pulses", pulses, 48);
          chk("cs_low_cycles", cs_len, CS_LOW_LEN);
          chk("setup_cycles", t_first_sclk - t_fall, SETUP_LEN);
          chk("hold_cycles", hold_len, HOLD_LEN);
          chk("sclk_period", period, SCLK_PERIOD);
          chk("cs_glitch", multi_low, 1'b0);
          if (cur.gap >= 0) chk("inter_frame_gap", gap, cur.gap);
        end
      end
      if (prev_busy && !ifa.busy) chk("busy_after_cs", cyc - t_rise, IDLE_GAP);
      prev_cs   = ifa.cs_n;
      prev_mclk = ifa.mclk;
      prev_busy = ifa.busy;
    end
  end

  // ---------------- monitor for the CLK_DIV=2 instance ----------------
  logic [3:0] f_prev_cs = 4'hF;
  logic       f_prev_mclk = 1'b1;
  bit         f_in = 0;
  int         f_fall, f_pulses, f_period, f_last_rise, f_len;

  always @(negedge clk_100m) begin
    if (!rst_n) begin
      f_in        = 0;
      f_prev_cs   = 4'hF;
      f_prev_mclk = 1'b1;
    end else begin
      if (f_prev_cs == 4'hF && ifb.cs_n != 4'hF) begin
        f_in     = 1;
        f_fall   = cyc;
        f_pulses = 0;
        f_period = 0;
      end
      if (f_in && !f_prev_mclk && ifb.mclk) begin
        f_pulses++;
        if (f_pulses == 2) f_period = cyc - f_last_rise;
        f_last_rise = cyc;
      end
      if (f_in && ifb.cs_n == 4'hF) begin
        f_in  = 0;
        f_len = cyc - f_fall;
      end
      if (ifb.done) begin
        if (fast_q.size() == 0) chk("fast_unexpected_done", 1'b1, 1'b0);
        else begin
          fast_cur = fast_q.pop_front();
          chk("fast_rx_data", ifb.rx_data, fast_cur);
          chk("fast_pulses", f_pulses, 48);
          chk("fast_sclk_period", f_period, FAST_PERIOD);
          chk("fast_cs_low_cycles", f_len, FAST_LOW_LEN);
        end
      end
      f_prev_cs   = ifb.cs_n;
      f_prev_mclk = ifb.mclk;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_busy(input bit fast, input logic val, input int limit, input string name);
    int n;
    n = 0;
    while ((fast ? ifb.busy : ifa.busy) !== val && n < limit) begin
      @(negedge clk_100m);
      n++;
    end
    if ((fast ? ifb.busy : ifa.busy) !== val) chk(name, fast ? ifb.busy : ifa.busy, val);
  endtask

  task automatic pulse_start(input logic [1:0] sel, input logic [15:0] a, input logic [31:0] d);
    ifa.cs_sel  = sel;
    ifa.tx_addr = a;
    ifa.tx_data = d;
    ifa.start   = 1'b1;
    @(negedge clk_100m);
    ifa.start   = 1'b0;
  endtask

  bit busy_seen;

  initial begin
    rst_n       = 1'b0;
    ifa.start   = 1'b0;
    ifa.cs_sel  = 2'd0;
    ifa.tx_addr = '0;
    ifa.tx_data = '0;
    ifb.start   = 1'b0;
    ifb.cs_sel  = 2'd0;
    ifb.tx_addr = '0;
    ifb.tx_data = '0;
    slave_word  = '0;
    repeat (3) @(negedge clk_100m);

    chk("reset_cs_n", ifa.cs_n, 4'hF);
    chk("reset_mclk", ifa.mclk, 1'b1);
    chk("reset_mosi", ifa.mosi, 1'b1);
    chk("reset_busy", ifa.busy, 1'b0);
    chk("reset_done", ifa.done, 1'b0);
    chk("reset_rx_data", ifa.rx_data, 32'h0);
    rst_n = 1'b1;
    @(negedge clk_100m);

    // Frame A: reference transfer; inputs scrambled right after accept.
    slave_word = 32'hA5A5_0F0F;
    expect_frame(16'h0105, 32'hDEADBEEF, 32'hA5A5_0F0F, 4'b1011, -1);
    pulse_start(2'd2, 16'h0105, 32'hDEADBEEF);
    chk("accept_busy", ifa.busy, 1'b1);
    chk("accept_cs_n", ifa.cs_n, 4'b1011);
    chk("accept_mosi", ifa.mosi, 1'b0);
    ifa.cs_sel  = 2'd0;
    ifa.tx_addr = 16'hFFFF;
    ifa.tx_data = 32'h0;
    wait_busy(0, 1'b0, 1000, "frameA_timeout");

    // Frame B: a second start in the data phase must be dropped.
    slave_word = 32'h3C5A_96F0;
    expect_frame(16'h1234, 32'h0F1E2D3C, 32'h3C5A_96F0, 4'b1101, -1);
    pulse_start(2'd1, 16'h1234, 32'h0F1E2D3C);
    chk("rx_hold_start", ifa.rx_data, 32'hA5A5_0F0F);
    repeat (4 + 28 * 10 + 3) @(negedge clk_100m);
    pulse_start(2'd3, 16'hABCD, 32'h55AA55AA);
    chk("rx_hold_mid", ifa.rx_data, 32'hA5A5_0F0F);
    wait_busy(0, 1'b0, 1000, "frameB_timeout");
    busy_seen = 0;
    repeat (30) begin
      @(negedge clk_100m);
      if (ifa.busy) busy_seen = 1;
    end
    chk("no_queued_frame", busy_seen, 1'b0);

    // Reset in the low half of bit 20; no done may follow.
    slave_word = 32'h1234_5678;
    pulse_start(2'd0, 16'h8001, 32'h0000_0000);
    repeat (4 + 200 + 2) @(negedge clk_100m);
    chk("pre_reset_cs_n", ifa.cs_n, 4'b1110);
    chk("pre_reset_mclk", ifa.mclk, 1'b0);
    chk("pre_reset_mosi", ifa.mosi, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_cs_n", ifa.cs_n, 4'hF);
    chk("async_mclk", ifa.mclk, 1'b1);
    chk("async_mosi", ifa.mosi, 1'b1);
    chk("async_busy", ifa.busy, 1'b0);
    chk("async_rx_data", ifa.rx_data, 32'h0);
    repeat (3) @(negedge clk_100m);

    // Frame C: start present on the first edge after reset release.
    slave_word = 32'hC3C3_0001;
    expect_frame(16'h7E81, 32'h8000_0001, 32'hC3C3_0001, 4'b0111, -1);
    ifa.cs_sel  = 2'd3;
    ifa.tx_addr = 16'h7E81;
    ifa.tx_data = 32'h8000_0001;
    rst_n       = 1'b1;
    ifa.start   = 1'b1;
    @(negedge clk_100m);
    ifa.start = 1'b0;
    chk("post_reset_busy", ifa.busy, 1'b1);
    chk("post_reset_cs_n", ifa.cs_n, 4'b0111);
    wait_busy(0, 1'b0, 1000, "frameC_timeout");

    // Held start: three back-to-back frames, slave index changed between them.
    slave_word = 32'h0F0F_0F0F;
    expect_frame(16'h00AA, 32'h11223344, 32'h0F0F_0F0F, 4'b1110, -1);
    expect_frame(16'h00AA, 32'h11223344, 32'h0F0F_0F0F, 4'b1101, IDLE_GAP + 1);
    expect_frame(16'h00AA, 32'h11223344, 32'h0F0F_0F0F, 4'b0111, IDLE_GAP + 1);
    ifa.cs_sel  = 2'd0;
    ifa.tx_addr = 16'h00AA;
    ifa.tx_data = 32'h11223344;
    ifa.start   = 1'b1;
    wait_busy(0, 1'b1, 20, "held1_start_timeout");
    ifa.cs_sel = 2'd1;
    wait_busy(0, 1'b0, 1000, "held1_end_timeout");
    wait_busy(0, 1'b1, 20, "held2_start_timeout");
    ifa.cs_sel = 2'd3;
    wait_busy(0, 1'b0, 1000, "held2_end_timeout");
    wait_busy(0, 1'b1, 20, "held3_start_timeout");
    ifa.start = 1'b0;
    wait_busy(0, 1'b0, 1000, "held3_end_timeout");

    // Fast instance: CLK_DIV=2, MISO tied high.
    fast_q.push_back(32'hFFFF_FFFF);
    ifb.cs_sel  = 2'd1;
    ifb.tx_addr = 16'h1357;
    ifb.tx_data = 32'h2468ACE0;
    ifb.start   = 1'b1;
    @(negedge clk_100m);
    ifb.start = 1'b0;
    wait_busy(1, 1'b0, 1000, "fast_timeout");

    repeat (20) @(negedge clk_100m);
    chk("frames_outstanding", exp_q.size(), 0);
    chk("fast_frames_outstanding", fast_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
    $fatal(1, "watchdog");
  end

endmodule
